// File: rtl/pwm_fader_pkg.sv
// Shared constants, register map and FSM encoding for the PWM soft-start fader.
package pwm_fader_pkg;

  localparam int DUTY_MAX = 100;

  localparam logic REG_TARGET = 1'b0;
  localparam logic REG_RATE   = 1'b1;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    WAIT = 2'd2,
    STEP = 2'd3
  } state_t;

  // Full 32-bit unsigned compare so large writes saturate instead of wrapping.
  function automatic logic [6:0] clamp_duty(input logic [31:0] v);
    return (v > 32'(DUTY_MAX)) ? 7'(DUTY_MAX) : v[6:0];
  endfunction

endpackage

// File: rtl/pwm_fader_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks.
module tick_gen #(
  parameter int TICK_DIV = 1334
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  // Count 0..TICK_DIV-1, wrapping on the tick edge.
  always_ff @(posedge clk) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pwm_fader.sv
// Soft-start controller: ramps the PWM duty register one unit per RATE ticks
// toward a CPU-written target, issuing a single-cycle write strobe per step.
//
//   state | meaning
//   INIT  | force PWM duty register to 0 once after reset
//   IDLE  | current == target, waiting for a new target
//   WAIT  | counting ticks until the next step is due
//   STEP  | update current and strobe the PWM
module pwm_fader #(
  parameter int TICK_DIV = 1334
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        A,
  input  logic [31:0] WD,
  input  logic        WE,
  output logic [31:0] RD,
  output logic [6:0]  duty,
  output logic        duty_we,
  output logic        busy
);

  import pwm_fader_pkg::*;

  state_t     state;
  logic [6:0] target;
  logic [6:0] current;
  logic [7:0] rate;
  logic [7:0] step_cnt;
  logic [8:0] cnt_inc;
  logic [6:0] next_cur;
  logic       tick;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign cnt_inc = {1'b0, step_cnt} + 9'd1;
  assign busy    = ((state != IDLE) && (state != INIT)) || (current != target);

  // Value current takes in STEP (only meaningful when current != target).
  always_comb begin
    next_cur = current;
    if (rate == 8'd0)          next_cur = target;
    else if (target > current) next_cur = current + 7'd1;
    else                       next_cur = current - 7'd1;
  end

  // Register file, step sequencer and registered PWM write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= INIT;
      target   <= '0;
      current  <= '0;
      rate     <= '0;
      step_cnt <= '0;
      duty     <= '0;
      duty_we  <= 1'b0;
    end else begin
      duty_we <= 1'b0;

      if (WE) begin
        if (A == REG_TARGET) target <= clamp_duty(WD);
        else                 rate   <= WD[7:0];
      end

      case (state)
        INIT: begin
          duty    <= '0;
          duty_we <= 1'b1;
          state   <= IDLE;
        end
        IDLE: begin
          if (current != target) begin
            if (rate == 8'd0) begin
              state <= STEP;
            end else begin
              step_cnt <= '0;
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          // >= so a rate lowered below the running count steps on the next tick.
          if (tick) begin
            step_cnt <= cnt_inc[7:0];
            if (cnt_inc >= {1'b0, rate}) state <= STEP;
          end
        end
        STEP: begin
          if (current == target) begin
            state <= IDLE;
          end else begin
            current <= next_cur;
            duty    <= next_cur;
            duty_we <= 1'b1;
            if (next_cur == target) begin
              state <= IDLE;
            end else begin
              step_cnt <= '0;
              state    <= WAIT;
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Bus read mux.
  always_comb begin
    RD = '0;
    if (A == REG_TARGET) begin
      RD[6:0]  = target;
      RD[14:8] = current;
      RD[31]   = busy;
    end else begin
      RD[7:0] = rate;
    end
  end

endmodule

// File: doc/pwm_fader.md
Name: pwm_fader

Overview:
- Memory-mapped soft-start controller that sits directly upstream of the 1 kHz PWM peripheral and drives that peripheral's duty-cycle write port.
- The CPU writes a target duty (0..100) and a ramp rate.
- The block steps the PWM duty one unit at a time toward the target, pacing the steps with a prescaled tick.
- Each step issues a single-cycle write strobe to the PWM.

Parameters:
- TICK_DIV, 1334, clk cycles per tick (one PWM counter increment at default).
- DUTY_MAX, 100, upper clamp for duty values.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- A  in  1  register select: 0 = TARGET, 1 = RATE
- WD  in  32  bus write data
- WE  in  1  bus write enable
- RD  out  32  bus read data (combinational)
- duty  out  7  duty value to PWM WD[6:0] (registered)
- duty_we  out  1  one-cycle write strobe to PWM WE (registered)
- busy  out  1  high while current != target or a step is pending

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - target=0, rate=0, current=0, duty=0, duty_we=0, busy=0.
  - Prescaler and step counter cleared; state=INIT.
  - Reset mid-ramp aborts the ramp immediately; no further strobes are issued except the INIT write.
- Writes:
  - WE&&A==0: target <= (WD>DUTY_MAX, unsigned 32-bit compare) ? DUTY_MAX : WD[6:0].
  - WE&&A==1: rate <= WD[7:0].
  - Registers update at the WE edge.
- Reads:
  - A==0: RD[6:0]=target, RD[14:8]=current, RD[31]=busy, all other bits 0.
  - A==1: RD[7:0]=rate, all other bits 0.
- Prescaler:
  - Free-running 0..TICK_DIV-1.
  - tick is high for one cycle when the count equals TICK_DIV-1; the counter wraps to 0 on the same edge.
- FSM states and transitions:
  - INIT: duty=0, duty_we=1 for exactly one cycle (forces the un-reset PWM register to 0), then IDLE.
  - IDLE: if current!=target: go to STEP if rate==0, else clear the step counter and go to WAIT. Otherwise stay.
  - WAIT: step counter increments on each tick; when it reaches rate, go to STEP.
  - STEP:
    - If current==target (target was rewritten), return to IDLE with no strobe.
    - Else if rate==0: current=target, a single jump.
    - Else: current +=1 if target>current, or -=1 if target<current.
    - duty<=new current and duty_we<=1 for one cycle.
    - Next state is IDLE if new current==target, else WAIT (step counter cleared).
- Latency: with rate==0, duty_we is asserted in the cycle beginning 2 edges after the target-write edge.
- Step spacing with rate=R: R ticks. Steps are tick-aligned, so the first step arrives within (R-1)*TICK_DIV+1 to R*TICK_DIV cycles of entering WAIT.
- Simultaneous events:
  - A target write in the same cycle as STEP: STEP uses the old target; the new target is seen from the next cycle.
  - A rate write during WAIT takes effect from the next tick. If the step count is already >= the new rate, STEP occurs on that next tick.
- busy = (state!=IDLE && state!=INIT) || current!=target.
- duty_we is never high for two consecutive cycles. duty never exceeds DUTY_MAX.

Decomposition:
- Shared package holds: DUTY_MAX, the register offsets (REG_TARGET=0, REG_RATE=1), and the FSM state encoding (INIT, IDLE, WAIT, STEP).
- One sub-module: tick_gen. Parameter TICK_DIV; ports clk, rst_n, tick out; the prescaler lives there.

Test Plan (TICK_DIV overridden to 4 for speed except where noted):
- Reset release -> exactly one duty_we pulse with duty=0; busy=0; RD(A=0)=0.
- rate=0, write target=50 -> one duty_we with duty=50 two edges after the write; RD[14:8]=50; busy returns to 0.
- rate=2, target 0->3 -> three strobes, duty=1,2,3, spaced 8 cycles; busy high until after the strobe carrying duty=3.
- Write target=200 -> RD[6:0]=100; the ramp ends at duty=100; no strobe ever carries a value >100.
- Mid-ramp retarget: ramping up at current=5, write target=2 -> subsequent strobes are 4,3,2. Retarget to exactly current -> no strobe; IDLE.
- Reset asserted mid-ramp at current=7 -> after release, a single strobe duty=0 and no further strobes.
